// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the ALU
// writeback (port A) and the load writeback (port M). Each port has a
// one-entry holding buffer. A round-robin arbiter drains one write per cycle.
// Writes to register 0 are dropped without asserting WriteReg.
// Optional feature macro: WB_SCOREBOARD_EN (adds the per-register busy port).
module regfile_wb_arbiter #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_vld,
  output logic          a_rdy,
  input  logic [AW-1:0] a_dst,
  input  logic [DW-1:0] a_data,
  input  logic          m_vld,
  output logic          m_rdy,
  input  logic [AW-1:0] m_dst,
  input  logic [DW-1:0] m_data,
  input  logic          hold,
  output logic          WriteReg,
  output logic [AW-1:0] DstReg,
  output logic [DW-1:0] DstData
`ifdef WB_SCOREBOARD_EN
  ,
  output logic [15:0]   busy
`endif
);

  localparam int unsigned NBUSY = 16;

  typedef enum logic {
    LG_A = 1'b0,
    LG_M = 1'b1
  } grant_t;

  grant_t        last_q;
  grant_t        last_d;

  logic          a_held;
  logic [AW-1:0] a_dst_q;
  logic [DW-1:0] a_data_q;
  logic          m_held;
  logic [AW-1:0] m_dst_q;
  logic [DW-1:0] m_data_q;

  logic          a_elig;
  logic          m_elig;
  logic          grant_a;
  logic          grant_m;
  logic          drain_a;
  logic          drain_m;

  // last-grant state register; A wins the first tie after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= LG_M;
    end else begin
      last_q <= last_d;
    end
  end

  // arbitration, drain control, handshakes and write-port outputs
  always_comb begin
    last_d   = last_q;
    a_elig   = 1'b0;
    m_elig   = 1'b0;
    grant_a  = 1'b0;
    grant_m  = 1'b0;
    drain_a  = 1'b0;
    drain_m  = 1'b0;
    WriteReg = 1'b0;
    DstReg   = '0;
    DstData  = '0;

    if (!hold) begin
      a_elig  = a_held && (a_dst_q != '0);
      m_elig  = m_held && (m_dst_q != '0);
      grant_a = a_elig && (!m_elig || (last_q == LG_M));
      grant_m = m_elig && (!a_elig || (last_q == LG_A));
      // zero-dst entries vanish alongside whatever the other port does
      drain_a = grant_a || (a_held && (a_dst_q == '0));
      drain_m = grant_m || (m_held && (m_dst_q == '0));
    end

    if (grant_a) begin
      last_d   = LG_A;
      WriteReg = 1'b1;
      DstReg   = a_dst_q;
      DstData  = a_data_q;
    end else if (grant_m) begin
      last_d   = LG_M;
      WriteReg = 1'b1;
      DstReg   = m_dst_q;
      DstData  = m_data_q;
    end

    a_rdy = !a_held || drain_a;
    m_rdy = !m_held || drain_m;
  end

  // port A holding buffer: refill takes priority over drain on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_held   <= 1'b0;
      a_dst_q  <= '0;
      a_data_q <= '0;
    end else if (a_vld && a_rdy) begin
      a_held   <= 1'b1;
      a_dst_q  <= a_dst;
      a_data_q <= a_data;
    end else if (drain_a) begin
      a_held   <= 1'b0;
    end
  end

  // port M holding buffer: refill takes priority over drain on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_held   <= 1'b0;
      m_dst_q  <= '0;
      m_data_q <= '0;
    end else if (m_vld && m_rdy) begin
      m_held   <= 1'b1;
      m_dst_q  <= m_dst;
      m_data_q <= m_data;
    end else if (drain_m) begin
      m_held   <= 1'b0;
    end
  end

`ifdef WB_SCOREBOARD_EN
  // pending-write flags decoded from the held buffers; register 0 never busy
  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < NBUSY; r++) begin
      if (a_held && (a_dst_q == AW'(r))) busy[r] = 1'b1;
      if (m_held && (m_dst_q == AW'(r))) busy[r] = 1'b1;
    end
  end
`endif

endmodule
